// File: rtl/umul_add.sv
// Sequential unsigned shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// Optional early termination on an exhausted multiplier is enabled by defining UMUL_EARLY_TERM_EN.
module umul_add #(
    parameter int DWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  input_data_valid,
    output logic                  input_ready_for_data,
    input  logic [DWIDTH-1:0]     multiplicand,
    input  logic [DWIDTH-1:0]     multiplier,
    input  logic [DWIDTH-1:0]     addend,
    output logic                  output_data_valid,
    output logic [2*DWIDTH-1:0]   product,
    output logic                  overflow
);
    localparam int CW = (DWIDTH > 2) ? $clog2(DWIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(DWIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [2*DWIDTH-1:0]    mcand_sr;
    logic [DWIDTH-1:0]      mplier_sr;
    logic [2*DWIDTH-1:0]    acc;
    logic [CW-1:0]          cnt;
    logic                   step_last;

`ifdef UMUL_EARLY_TERM_EN
    // Stop as soon as no set multiplier bits remain after this step's shift.
    assign step_last = (cnt == LAST_STEP) || (mplier_sr[DWIDTH-1:1] == '0);
`else
    assign step_last = (cnt == LAST_STEP);
`endif

    assign input_ready_for_data = (state == IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (input_data_valid) state_nxt = CALC;
            CALC:    if (step_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_sr          <= '0;
            mplier_sr         <= '0;
            acc               <= '0;
            cnt               <= '0;
            product           <= '0;
            overflow          <= 1'b0;
            output_data_valid <= 1'b0;
        end else if (ce) begin
            output_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (input_data_valid) begin
                        mcand_sr  <= {{DWIDTH{1'b0}}, multiplicand};
                        mplier_sr <= multiplier;
                        acc       <= {{DWIDTH{1'b0}}, addend};
                        cnt       <= '0;
                    end
                end
                CALC: begin
                    if (mplier_sr[0]) acc <= acc + mcand_sr;
                    mcand_sr  <= mcand_sr << 1;
                    mplier_sr <= mplier_sr >> 1;
                    cnt       <= cnt + CW'(1);
                end
                DONE: begin
                    product           <= acc;
                    overflow          <= |acc[2*DWIDTH-1:DWIDTH];
                    output_data_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_umul_add.sv
// Scoreboard bench for umul_add: a watcher queues a*b+c per accept, a monitor checks each valid strobe.
module tb_umul_add;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ce = 1'b1;
    logic           input_data_valid = 1'b0;
    logic           input_ready_for_data;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic [W-1:0]   addend = '0;
    logic           output_data_valid;
    logic [2*W-1:0] product;
    logic           overflow;

    umul_add #(.DWIDTH(W)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .input_data_valid(input_data_valid),
        .input_ready_for_data(input_ready_for_data),
        .multiplicand(multiplicand), .multiplier(multiplier), .addend(addend),
        .output_data_valid(output_data_valid),
        .product(product), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ce_cyc = 0;
    int acc_cnt = 0;
    int val_cnt = 0;
    int last_acc_cyc = 0;
    int last_raw_lat = 0;
    logic last_ce = 1'b0;
    logic rdy_s = 1'b0;
    logic ce_rand = 1'b0;
    logic [2*W-1:0] cur_exp = '0;

    logic [2*W-1:0] exp_q[$];
    int             acc_ce_q[$];
    int             acc_raw_q[$];
    int             lat_q[$];

    // Cycles from accept edge to the cycle in which the strobe is visible, plus one.
    function automatic int lat_of(input logic [W-1:0] b);
        int h;
        h = 0;
        for (int i = 0; i < W; i++) if (b[i]) h = i + 1;
`ifdef UMUL_EARLY_TERM_EN
        if (h < 1) h = 1;
        return h + 2;
`else
        if (h > W) return 0;
        return W + 2;
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) rdy_s <= input_ready_for_data;

    always @(negedge clk) if (ce_rand) ce = ($urandom_range(0, 3) != 0);

    // Accept watcher: operands were driven at the previous negedge.
    always @(posedge clk) begin
        cyc++;
        last_ce = ce;
        if (ce) ce_cyc++;
        if (!rst && ce && input_data_valid && rdy_s) begin
            exp_q.push_back(cur_exp);
            acc_ce_q.push_back(ce_cyc);
            acc_raw_q.push_back(cyc);
            lat_q.push_back(lat_of(multiplier));
            acc_cnt++;
            last_acc_cyc = cyc;
        end
    end

    // Monitor: one check set per strobe (re-checked only after an edge with ce high).
    always @(negedge clk) begin
        if (!rst && last_ce && output_data_valid) begin
            val_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                logic [2*W-1:0] e;
                int a_ce, a_raw, l;
                e = exp_q.pop_front();
                a_ce = acc_ce_q.pop_front();
                a_raw = acc_raw_q.pop_front();
                l = lat_q.pop_front();
                check("product", product, e);
                check("overflow", overflow, |e[2*W-1:W]);
                check("latency_ce", ce_cyc - a_ce, l - 1);
                check("ready_with_valid", input_ready_for_data, 1);
                last_raw_lat = cyc - a_raw;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [2*W-1:0] e);
        int n0;
        bit got;
        @(negedge clk);
        multiplicand = a; multiplier = b; addend = c; cur_exp = e;
        input_data_valid = 1'b1;
        n0 = acc_cnt;
        got = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (acc_cnt != n0) got = 1;
        end
        input_data_valid = 1'b0;
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        issue(a, b, c, (2*W)'(32'(a) * 32'(b) + 32'(c)));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int n0, c0, c1, vc;
        logic [W-1:0] dvd, dvs;
        logic [2*W-1:0] held;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", input_ready_for_data, 1);
        check("rst_valid", output_data_valid, 0);
        check("rst_product", product, 0);
        check("rst_overflow", overflow, 0);

        // Directed results and boundaries.
        op(8'd13, 8'd19, 8'd5);
        drain();
        check("t1_product", product, 16'h00FC);
        op(8'd255, 8'd255, 8'd255);
        drain();
        check("t2_product", product, 16'hFF00);
        check("t2_overflow", overflow, 1);
        op(8'd28, 8'd7, 8'd4);
        drain();
        check("t3_product", product, 16'h00C8);
        op(8'd9, 8'd0, 8'd200);
        op(8'd200, 8'd1, 8'd0);
        op(8'd3, 8'h80, 8'd1);
        op(8'd0, 8'd0, 8'd0);
        drain();

        // Product holds across a new accept.
        held = product;
        op(8'd77, 8'd99, 8'd1);
        repeat (2) @(negedge clk);
        check("hold_product", product, held);
        drain();

        // Divider reconstruction sweep.
        for (int i = 0; i < 1000; i++) begin
            dvd = W'($urandom);
            dvs = W'($urandom_range(1, (1 << W) - 1));
            issue(dvd / dvs, dvs, dvd % dvs, {{W{1'b0}}, dvd});
        end
        drain();

        // Valid held high: exactly two accepts, one latency apart.
        @(negedge clk);
        n0 = acc_cnt;
        multiplicand = 8'd3; multiplier = 8'd4; addend = 8'd1; cur_exp = 16'd13;
        input_data_valid = 1'b1;
        for (int k = 0; k < 100 && acc_cnt == n0; k++) @(negedge clk);
        c0 = last_acc_cyc;
        multiplicand = 8'd0; multiplier = 8'd77; addend = 8'd9; cur_exp = 16'd9;
        for (int k = 0; k < 100 && acc_cnt == n0 + 1; k++) @(negedge clk);
        c1 = last_acc_cyc;
        input_data_valid = 1'b0;
        check("t4_accept_gap", c1 - c0, lat_of(8'd4));
        drain();
        repeat (W + 4) @(negedge clk);
        check("t4_accept_count", acc_cnt - n0, 2);

        // Reset mid-calculation aborts the op.
        vc = val_cnt;
        op(8'd100, 8'd200, 8'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete(); acc_ce_q.delete(); acc_raw_q.delete(); lat_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("t5_no_valid", val_cnt - vc, 0);
        check("t5_product", product, 0);
        check("t5_ready", input_ready_for_data, 1);
        op(8'd2, 8'd3, 8'd0);
        drain();
        check("t5_next_product", product, 6);

        // ce low for three cycles mid-CALC delays the strobe by three.
        op(8'd201, 8'h85, 8'd17);
        repeat (2) @(negedge clk);
        ce = 1'b0;
        repeat (3) @(negedge clk);
        ce = 1'b1;
        drain();
        check("t6_raw_latency", last_raw_lat, lat_of(8'h85) - 1 + 3);
        check("t6_product", product, 16'(201 * 8'h85 + 17));

        // Random stream with random ce gaps.
        ce_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra, rb, rc;
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
            rc = W'($urandom);
            op(ra, rb, rc);
        end
        drain();
        ce_rand = 1'b0;
        @(negedge clk);
        ce = 1'b1;
        repeat (W + 4) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end
endmodule
